// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM forward cell: Q8.24 constants and FSM encoding.
package lstm_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 24;

    localparam logic [31:0] FX_ONE  = 32'h0100_0000;
    localparam logic [31:0] FX_ZERO = 32'h0000_0000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MUL_AI = 3'd1;
    localparam logic [2:0] ST_MUL_FS = 3'd2;
    localparam logic [2:0] ST_ADD    = 3'd3;
    localparam logic [2:0] ST_TANH   = 3'd4;
    localparam logic [2:0] ST_MUL_OH = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        MUL_AI = ST_MUL_AI,
        MUL_FS = ST_MUL_FS,
        ADD    = ST_ADD,
        TANH   = ST_TANH,
        MUL_OH = ST_MUL_OH,
        DONE   = ST_DONE
    } lstm_state_e;

endpackage

// File: rtl/mult_2in.sv
// Signed fixed-point multiplier: full double-width product, truncated back to
// WIDTH bits by dropping FRAC fraction bits and the overflowing top bits.
module mult_2in #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] p_o
);

    // Sign-extend both operands, multiply, arithmetic-shift out the fraction, keep WIDTH bits.
    assign p_o = WIDTH'(((2*WIDTH)'(a_i) * (2*WIDTH)'(b_i)) >>> FRAC);

endmodule

// File: rtl/tanh.sv
// Piecewise-linear tanh approximation in signed fixed point.
// Segments on |x|: [0,0.5) -> x, [0.5,1) -> x/2+0.25, [1,2) -> x/4+0.5, >=2 -> 1.0.
// The curve is odd-symmetric, so the sign is stripped first and restored at the end.
module tanh #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] y_o
);

    localparam logic [WIDTH-1:0] LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE  = LSB << FRAC;
    localparam logic [WIDTH-1:0] HALF = ONE >> 1;
    localparam logic [WIDTH-1:0] QTR  = ONE >> 2;
    localparam logic [WIDTH-1:0] TWO  = ONE << 1;

    logic             neg_s;
    logic [WIDTH-1:0] mag_s;
    logic [WIDTH-1:0] ymag_s;

    // Magnitude as unsigned; the most negative input maps to 2^(WIDTH-1), which saturates.
    always_comb begin
        neg_s = x_i[WIDTH-1];
        if (neg_s) begin
            mag_s = ~x_i + LSB;
        end else begin
            mag_s = x_i;
        end
    end

    // Segment selection on the magnitude.
    always_comb begin
        if (mag_s < HALF) begin
            ymag_s = mag_s;
        end else if (mag_s < ONE) begin
            ymag_s = (mag_s >> 1) + QTR;
        end else if (mag_s < TWO) begin
            ymag_s = (mag_s >> 2) + HALF;
        end else begin
            ymag_s = ONE;
        end
    end

    // Restore the sign.
    always_comb begin
        if (neg_s) begin
            y_o = ~ymag_s + LSB;
        end else begin
            y_o = ymag_s;
        end
    end

endmodule

// File: rtl/lstm_fwd_cell.sv
// Forward LSTM cell for one hidden unit: state = at*it + ft*state_prev,
// h = ot*tanh(state). One shared multiplier, sequenced by a 7-state FSM;
// one result every 7 cycles with a start/done handshake.
module lstm_fwd_cell
    import lstm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] at,
    input  logic [WIDTH-1:0] it,
    input  logic [WIDTH-1:0] ft,
    input  logic [WIDTH-1:0] ot,
    input  logic [WIDTH-1:0] state_prev,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_state,
    output logic [WIDTH-1:0] o_h
);

    lstm_state_e state_q, state_d;

    logic [WIDTH-1:0] at_q, it_q, ft_q, ot_q, sp_q;
    logic [WIDTH-1:0] p1_q, p2_q, cell_q, th_q, h_q;
    logic             busy_q, done_q;

    logic [WIDTH-1:0] mul_a_s, mul_b_s, mul_p_s;
    logic [WIDTH-1:0] th_s;

    mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mult (
        .a_i (mul_a_s),
        .b_i (mul_b_s),
        .p_o (mul_p_s)
    );

    tanh #(.WIDTH(WIDTH), .FRAC(FRAC)) u_tanh (
        .x_i (cell_q),
        .y_o (th_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a fixed walk through the schedule once started.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = MUL_AI;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL_AI:  state_d = MUL_FS;
            MUL_FS:  state_d = ADD;
            ADD:     state_d = TANH;
            TANH:    state_d = MUL_OH;
            MUL_OH:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand select for the shared multiplier, driven by the current step.
    always_comb begin
        mul_a_s = FX_ZERO[WIDTH-1:0];
        mul_b_s = FX_ZERO[WIDTH-1:0];
        case (state_q)
            MUL_AI: begin
                mul_a_s = at_q;
                mul_b_s = it_q;
            end
            MUL_FS: begin
                mul_a_s = ft_q;
                mul_b_s = sp_q;
            end
            MUL_OH: begin
                mul_a_s = ot_q;
                mul_b_s = th_q;
            end
            default: begin
                mul_a_s = FX_ZERO[WIDTH-1:0];
                mul_b_s = FX_ZERO[WIDTH-1:0];
            end
        endcase
    end

    // Datapath registers: operand capture at start, then one result per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            at_q   <= '0;
            it_q   <= '0;
            ft_q   <= '0;
            ot_q   <= '0;
            sp_q   <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            cell_q <= '0;
            th_q   <= '0;
            h_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        at_q <= at;
                        it_q <= it;
                        ft_q <= ft;
                        ot_q <= ot;
                        sp_q <= state_prev;
                    end
                end
                MUL_AI:  p1_q   <= mul_p_s;
                MUL_FS:  p2_q   <= mul_p_s;
                ADD:     cell_q <= p1_q + p2_q;
                TANH:    th_q   <= th_s;
                MUL_OH:  h_q    <= mul_p_s;
                default: begin
                end
            endcase
        end
    end

    // Handshake flags registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_d == DONE);
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_state = cell_q;
    assign o_h     = h_q;

endmodule

// File: tb/tb_lstm_fwd_cell.sv
// Self-checking bench for lstm_fwd_cell: a cycle model predicts busy/done and
// the visible outputs every cycle; a scoreboard queue holds the expected
// result of each accepted start and is compared when o_done pulses.
module tb_lstm_fwd_cell;

    typedef struct {
        logic [31:0] st;
        logic [31:0] h;
    } result_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] at, it, ft, ot, state_prev;
    logic        o_busy, o_done;
    logic [31:0] o_state, o_h;

    int          checks = 0;
    int          errors = 0;
    logic        chk_en = 1'b0;

    result_t     sb[$];
    int          cnt = 0;
    logic [31:0] cur_state = 32'h0;
    logic [31:0] cur_h     = 32'h0;
    logic [31:0] pend_state, pend_h;

    lstm_fwd_cell #(.WIDTH(32), .FRAC(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .at         (at),
        .it         (it),
        .ft         (ft),
        .ot         (ot),
        .state_prev (state_prev),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_state    (o_state),
        .o_h        (o_h)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference Q8.24 multiply: exact 64-bit product, drop 24 fraction bits, wrap to 32.
    function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 24;
        return p[31:0];
    endfunction

    // Reference tanh: same piecewise curve written with signed integer arithmetic.
    function automatic logic [31:0] ref_tanh(input logic [31:0] x);
        longint v, a, y;
        v = longint'($signed(x));
        a = (v < 0) ? -v : v;
        if (a < 64'sd8388608)       y = a;
        else if (a < 64'sd16777216) y = a / 2 + 64'sd4194304;
        else if (a < 64'sd33554432) y = a / 4 + 64'sd8388608;
        else                        y = 64'sd16777216;
        if (v < 0) y = -y;
        return y[31:0];
    endfunction

    // Cycle model: accepts starts only when idle, tracks when outputs become visible.
    always @(posedge clk) begin
        if (rst) begin
            cnt       = 0;
            cur_state = 32'h0;
            cur_h     = 32'h0;
            sb.delete();
        end else if (cnt == 0) begin
            if (i_start) begin
                result_t r;
                r.st = fx_mul(at, it) + fx_mul(ft, state_prev);
                r.h  = fx_mul(ot, ref_tanh(r.st));
                pend_state = r.st;
                pend_h     = r.h;
                sb.push_back(r);
                cnt = 6;
            end
        end else begin
            cnt--;
            if (cnt == 3) cur_state = pend_state;
            if (cnt == 1) cur_h = pend_h;
        end
    end

    // Compare DUT against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",    32'(o_busy),  32'(cnt != 0));
            check("done",    32'(o_done),  32'(cnt == 1));
            check("o_state", o_state, cur_state);
            check("o_h",     o_h,     cur_h);
            if (o_done) begin
                check("sb_depth", 32'(sb.size()), 32'd1);
                if (sb.size() != 0) begin
                    result_t e;
                    e = sb.pop_front();
                    check("sb_state", o_state, e.st);
                    check("sb_h",     o_h,     e.h);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] a, input logic [31:0] i, input logic [31:0] f,
                          input logic [31:0] o, input logic [31:0] s);
        at = a; it = i; ft = f; ot = o; state_prev = s;
    endtask

    // One full operation: start for one cycle, then wait out the remaining 6 cycles.
    task automatic op(input logic [31:0] a, input logic [31:0] i, input logic [31:0] f,
                      input logic [31:0] o, input logic [31:0] s);
        set_in(a, i, f, o, s);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (6) tick();
    endtask

    function automatic logic [31:0] rnd_fx();
        return $urandom_range(32'h0400_0000, 32'h0) - 32'h0200_0000;
    endfunction

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        set_in(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Basic: 0.5*1 + 0.5*1 = 1.0, ot = 0.
        op(32'h0080_0000, 32'h0100_0000, 32'h0080_0000, 32'h0000_0000, 32'h0100_0000);
        // Negative state, unity output gate.
        op(32'hFF00_0000, 32'h0100_0000, 32'h0000_0000, 32'h0100_0000, 32'h7FFF_FFFF);
        // Overflow wraps: 100*2 = 200 -> 0xC8000000.
        op(32'h6400_0000, 32'h0200_0000, 32'h0000_0000, 32'h0100_0000, 32'h1234_5678);
        // tanh segment coverage: 0.3, 0.75, 1.5, -3.0, most negative.
        op(32'h004C_CCCD, 32'h0100_0000, 32'h0000_0000, 32'h0100_0000, 32'h0);
        op(32'h00C0_0000, 32'h0100_0000, 32'h0000_0000, 32'h0080_0000, 32'h0);
        op(32'h0180_0000, 32'h0100_0000, 32'h0000_0000, 32'hFF80_0000, 32'h0);
        op(32'hFD00_0000, 32'h0100_0000, 32'h0000_0000, 32'h0100_0000, 32'h0);
        op(32'h8000_0000, 32'h0100_0000, 32'h0000_0000, 32'h0100_0000, 32'h0);

        // Start held every cycle with changing inputs: one accept per 7 cycles.
        for (int n = 0; n < 30; n++) begin
            set_in(rnd_fx(), rnd_fx(), rnd_fx(), rnd_fx(), rnd_fx());
            i_start = 1'b1;
            tick();
        end
        i_start = 1'b0;
        repeat (8) tick();

        // Reset while in TANH: abort with no done, then a clean operation.
        set_in(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        op(32'h0040_0000, 32'h0200_0000, 32'hFFC0_0000, 32'h0100_0000, 32'h0100_0000);

        // Reset and start together: reset wins.
        rst = 1'b1;
        i_start = 1'b1;
        tick();
        rst = 1'b0;
        i_start = 1'b0;
        repeat (2) tick();

        // Result hold: a completed op, then 20 idle cycles of toggling inputs.
        op(32'h0060_0000, 32'h0180_0000, 32'h0020_0000, 32'h00F0_0000, 32'hFE80_0000);
        for (int n = 0; n < 20; n++) begin
            set_in(rnd_fx(), rnd_fx(), rnd_fx(), rnd_fx(), rnd_fx());
            tick();
        end

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
